// File: rtl/sink_table_pkg.sv
// sink_table_pkg: shared constants, status codes and FSM encoding for the known-sinks table
package sink_table_pkg;
  localparam int SINK_ID_W = 5;
  localparam int SINK_SLOTS = 10;
  localparam logic [SINK_ID_W-1:0] INVALID_ID = '1;
  typedef enum logic [1:0] {
    ST_INSERTED = 2'b00,
    ST_DUP      = 2'b01,
    ST_FULL     = 2'b10,
    ST_INVALID  = 2'b11
  } status_t;
  typedef enum logic [1:0] {IDLE, SCAN, WRITE} state_t;
endpackage

// File: rtl/sink_table_builder_if.sv
// sink_table_builder_if: advertisement handshake plus per-advertisement completion result
interface sink_table_builder_if #(parameter int ID_W = 5);
  logic adv_valid;
  logic [ID_W-1:0] adv_id;
  logic adv_ready;
  logic done;
  logic [1:0] status;
  modport master(output adv_valid, adv_id, input adv_ready, done, status);
  modport slave(input adv_valid, adv_id, output adv_ready, done, status);
endinterface

// File: rtl/sink_table_builder.sv
// sink_table_builder: de-duplicating writer of the known-sinks table; define SINK_TABLE_REPLACE_EN to overwrite round-robin when full
module sink_table_builder
  import sink_table_pkg::*;
#(
  parameter int MAX_SINKS = SINK_SLOTS,
  parameter int ID_W = SINK_ID_W,
  localparam int CW = $clog2(MAX_SINKS + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  sink_table_builder_if.slave adv,
  output logic [MAX_SINKS*ID_W-1:0] known_sinks,
  output logic [CW-1:0] sink_count,
  output logic table_full
);
  localparam logic [ID_W-1:0] EMPTY = ID_W'(INVALID_ID);
  state_t state, nextState;
  status_t statusNext;
  logic doneNext;
  logic [CW-1:0] idx;
  logic [ID_W-1:0] latchedId;
  logic [ID_W-1:0] slots [MAX_SINKS];
  logic fire, hit, lastSlot, full;
`ifdef SINK_TABLE_REPLACE_EN
  logic [CW-1:0] replPtr;
`endif
  assign adv.adv_ready = state == IDLE;
  assign fire = adv.adv_valid && adv.adv_ready;
  assign full = sink_count == CW'(MAX_SINKS);
  assign hit = slots[idx] == latchedId;
  assign lastSlot = idx == sink_count - CW'(1);
  assign table_full = full;
  for (genvar k = 0; k < MAX_SINKS; k++) begin : g_flat
    assign known_sinks[k*ID_W +: ID_W] = slots[k];
  end
  // next state and completion result; clear overrides and suppresses done
  always_comb begin
    nextState = state;
    doneNext = 1'b0;
    statusNext = ST_INSERTED;
    if (state == IDLE && fire) begin
      if (adv.adv_id == EMPTY) begin
        doneNext = 1'b1;
        statusNext = ST_INVALID;
      end else begin
        nextState = (sink_count == '0) ? WRITE : SCAN;
      end
    end
    if (state == SCAN) begin
      if (hit) begin
        nextState = IDLE;
        doneNext = 1'b1;
        statusNext = ST_DUP;
      end else if (lastSlot) begin
        nextState = WRITE;
      end
    end
    if (state == WRITE) begin
      nextState = IDLE;
      doneNext = 1'b1;
      statusNext = full ? ST_FULL : ST_INSERTED;
    end
    if (clear) begin
      nextState = IDLE;
      doneNext = 1'b0;
    end
  end
  // state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= nextState;
  end
  // registered done pulse; status holds the last result between pulses
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      adv.done <= 1'b0;
      adv.status <= ST_INSERTED;
    end else begin
      adv.done <= doneNext;
      if (doneNext) adv.status <= statusNext;
    end
  end
  // table contents, scan index and latched advertisement
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx <= '0;
      latchedId <= EMPTY;
      sink_count <= '0;
      for (int k = 0; k < MAX_SINKS; k++) slots[k] <= EMPTY;
`ifdef SINK_TABLE_REPLACE_EN
      replPtr <= '0;
`endif
    end else if (clear) begin
      idx <= '0;
      sink_count <= '0;
      for (int k = 0; k < MAX_SINKS; k++) slots[k] <= EMPTY;
`ifdef SINK_TABLE_REPLACE_EN
      replPtr <= '0;
`endif
    end else begin
      if (state == IDLE && fire) begin
        latchedId <= adv.adv_id;
        idx <= '0;
      end
      if (state == SCAN && !hit) idx <= idx + CW'(1);
      if (state == WRITE && !full) begin
        slots[sink_count] <= latchedId;
        sink_count <= sink_count + CW'(1);
      end
`ifdef SINK_TABLE_REPLACE_EN
      if (state == WRITE && full) begin
        slots[replPtr] <= latchedId;
        replPtr <= (replPtr == CW'(MAX_SINKS - 1)) ? '0 : replPtr + CW'(1);
      end
`endif
    end
  end
endmodule

// File: tb/tb_sink_table_builder.sv
// tb_sink_table_builder: directed advertisements checked against a table model and hand-computed literals
module tb_sink_table_builder;
  localparam int N = 10;
  localparam int W = 5;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic clear = 1'b0;
  logic [N*W-1:0] known_sinks;
  logic [3:0] sink_count;
  logic table_full;
  sink_table_builder_if #(.ID_W(W)) adv ();
  sink_table_builder dut (
    .clock(clock), .reset(reset), .clear(clear), .adv(adv),
    .known_sinks(known_sinks), .sink_count(sink_count), .table_full(table_full)
  );
  always #5 clock = ~clock;
  int checks = 0;
  int passed = 0;
  int mTable [N];
  int mCount = 0;
  int mRepl = 0;
  bit busy = 1'b0;
  bit checkOn = 1'b0;
  localparam logic [N*W-1:0] ALL_ONES = '1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [N*W-1:0] flatModel();
    logic [N*W-1:0] r;
    r = '1;
    for (int k = 0; k < N; k++) if (k < mCount) r[k*W +: W] = W'(mTable[k]);
    return r;
  endfunction

  task automatic modelReset();
    mCount = 0;
    mRepl = 0;
    busy = 1'b0;
  endtask

  // every cycle: table outputs and ready must match the model
  always @(negedge clock) begin
    if (checkOn && !reset) begin
      check("known_sinks", 64'(known_sinks), 64'(flatModel()));
      check("sink_count", 64'(sink_count), 64'(mCount));
      check("table_full", 64'(table_full), 64'(mCount == N));
      check("adv_ready", 64'(adv.adv_ready), 64'(!busy));
    end
  end

  task automatic advertise(input int id, output int gotSt, output int gotLat);
    int k, lat, st;
    bit found;
    @(negedge clock);
    adv.adv_valid = 1'b1;
    adv.adv_id = W'(id);
    @(posedge clock);
    found = 1'b0;
    k = 0;
    for (int i = 0; i < mCount; i++) if (!found && mTable[i] == id) begin found = 1'b1; k = i; end
    if (id == 31) begin st = 3; lat = 0; end
    else if (found) begin st = 1; lat = k + 1; end
    else begin st = (mCount == N) ? 2 : 0; lat = (mCount == 0) ? 1 : mCount + 1; end
    #1;
    adv.adv_valid = 1'b0;
    adv.adv_id = W'($urandom);
    busy = lat != 0;
    gotLat = 0;
    while (!adv.done && gotLat < 40) begin
      @(posedge clock);
      #1;
      gotLat++;
    end
    check("latency", 64'(gotLat), 64'(lat));
    check("status", 64'(adv.status), 64'(st));
    gotSt = int'(adv.status);
    if (st == 0) begin mTable[mCount] = id; mCount++; end
`ifdef SINK_TABLE_REPLACE_EN
    if (st == 2) begin mTable[mRepl] = id; mRepl = (mRepl + 1) % N; end
`endif
    busy = 1'b0;
  endtask

  task automatic doClear();
    @(negedge clock);
    clear = 1'b1;
    @(posedge clock);
    #1;
    clear = 1'b0;
    modelReset();
  endtask

  initial begin
    int st, lat, dn;
    adv.adv_valid = 1'b0;
    adv.adv_id = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_known_sinks", 64'(known_sinks), 64'(ALL_ONES));
    check("rst_sink_count", 64'(sink_count), 64'd0);
    check("rst_adv_ready", 64'(adv.adv_ready), 64'd1);
    check("rst_done", 64'(adv.done), 64'd0);
    check("rst_status", 64'(adv.status), 64'd0);
    check("rst_table_full", 64'(table_full), 64'd0);
    reset = 1'b0;
    checkOn = 1'b1;
    advertise(3, st, lat);
    check("ins3_status", 64'(st), 64'd0);
    check("ins3_latency", 64'(lat), 64'd1);
    advertise(7, st, lat);
    check("ins7_status", 64'(st), 64'd0);
    check("ins7_latency", 64'(lat), 64'd2);
    advertise(3, st, lat);
    check("dup3_status", 64'(st), 64'd1);
    check("dup3_latency", 64'(lat), 64'd1);
    check("slot0", 64'(known_sinks[4:0]), 64'd3);
    check("slot1", 64'(known_sinks[9:5]), 64'd7);
    check("count2", 64'(sink_count), 64'd2);
    advertise(31, st, lat);
    check("inv_status", 64'(st), 64'd3);
    check("inv_latency", 64'(lat), 64'd0);
    check("inv_ready", 64'(adv.adv_ready), 64'd1);
    check("inv_count", 64'(sink_count), 64'd2);
    doClear();
    for (int i = 0; i < 10; i++) advertise(i, st, lat);
    check("fill_full", 64'(table_full), 64'd1);
    advertise(12, st, lat);
    check("full12_status", 64'(st), 64'd2);
    check("full12_latency", 64'(lat), 64'd11);
`ifdef SINK_TABLE_REPLACE_EN
    check("repl_slot0", 64'(known_sinks[4:0]), 64'd12);
    advertise(13, st, lat);
    check("repl_slot1", 64'(known_sinks[9:5]), 64'd13);
`else
    check("drop_slot0", 64'(known_sinks[4:0]), 64'd0);
    check("drop_slot9", 64'(known_sinks[49:45]), 64'd9);
`endif
    check("full_count", 64'(sink_count), 64'd10);
    advertise(5, st, lat);
    check("dup5_latency", 64'(lat), 64'd6);
    doClear();
    for (int i = 0; i < 9; i++) advertise(i, st, lat);
    advertise(20, st, lat);
    check("ins20_latency", 64'(lat), 64'd10);
    check("ins20_count", 64'(sink_count), 64'd10);
    @(negedge clock);
    adv.adv_valid = 1'b1;
    adv.adv_id = W'(25);
    @(posedge clock);
    #1;
    adv.adv_valid = 1'b0;
    busy = 1'b1;
    repeat (3) @(posedge clock);
    doClear();
    dn = 0;
    repeat (15) begin
      @(posedge clock);
      #1;
      if (adv.done) dn++;
    end
    check("clr_no_done", 64'(dn), 64'd0);
    check("clr_known_sinks", 64'(known_sinks), 64'(ALL_ONES));
    check("clr_count", 64'(sink_count), 64'd0);
    check("clr_ready", 64'(adv.adv_ready), 64'd1);
    advertise(4, st, lat);
    check("post_clr_latency", 64'(lat), 64'd1);
    advertise(9, st, lat);
    @(negedge clock);
    adv.adv_valid = 1'b1;
    adv.adv_id = W'(17);
    @(posedge clock);
    #1;
    adv.adv_valid = 1'b0;
    busy = 1'b1;
    @(posedge clock);
    #3;
    reset = 1'b1;
    modelReset();
    #1;
    check("arst_known_sinks", 64'(known_sinks), 64'(ALL_ONES));
    check("arst_count", 64'(sink_count), 64'd0);
    check("arst_ready", 64'(adv.adv_ready), 64'd1);
    @(negedge clock);
    reset = 1'b0;
    dn = 0;
    repeat (10) begin
      @(posedge clock);
      #1;
      if (adv.done) dn++;
    end
    check("arst_no_done", 64'(dn), 64'd0);
    advertise(6, st, lat);
    check("post_rst_status", 64'(st), 64'd0);
    check("post_rst_latency", 64'(lat), 64'd1);
    @(negedge clock);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
